// File: rtl/regfile_pkg.sv
// Shared constants, clear-engine state type and byte-merge helper for the register file.
package regfile_pkg;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 5;

  // Widest entry the merge helper handles; callers cast to and from this width.
  localparam int unsigned RF_MAX_W  = 256;
  localparam int unsigned RF_MAX_BE = RF_MAX_W / 8;

  typedef enum logic {
    RF_IDLE,
    RF_CLEAR
  } rf_state_t;

  function automatic logic [RF_MAX_W-1:0] rf_byte_merge(input logic [RF_MAX_W-1:0]  old_v,
                                                        input logic [RF_MAX_W-1:0]  new_v,
                                                        input logic [RF_MAX_BE-1:0] be);
    logic [RF_MAX_W-1:0] m;
    for (int unsigned i = 0; i < RF_MAX_BE; i++) begin
      m[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One asynchronous read port: address mux, zero-entry override and write bypass.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic [DATA_W-1:0] i_mem [2**ADDR_W],
  input  logic              i_wr_acc,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_merged,
  output logic [DATA_W-1:0] o_rd_data
);

  logic w_is_zero;
  logic w_hit;

  assign w_is_zero = (ZERO_REG != 0) && (i_rd_addr == '0);
  // i_wr_acc already excludes the zero entry and busy cycles.
  assign w_hit     = (BYPASS != 0) && i_wr_acc && (i_wr_addr == i_rd_addr);

  always_comb begin
    o_rd_data = i_mem[i_rd_addr];
    if (w_hit) begin
      o_rd_data = i_wr_merged;
    end
    if (w_is_zero) begin
      o_rd_data = '0;
    end
  end

endmodule

// File: rtl/regfile_param.sv
// Parametrised flop-based register file with byte-enabled writes and a bulk-clear engine.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic [DATA_W/8-1:0]       wr_be,
  output logic                      wr_ok,
  input  logic [NREAD*ADDR_W-1:0]   rd_addr,
  output logic [NREAD*DATA_W-1:0]   rd_data,
  input  logic                      clr_req,
  output logic                      busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  rf_state_t         r_state;
  rf_state_t         w_state_d;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_d;
  logic              w_wr_acc;
  logic [DATA_W-1:0] w_wr_merged;

  assign busy  = (r_state == RF_CLEAR);
  assign wr_ok = ~busy;

  assign w_wr_acc    = wr_en && !busy && !((ZERO_REG != 0) && (wr_addr == '0));
  assign w_wr_merged = DATA_W'(rf_byte_merge(RF_MAX_W'(r_mem[wr_addr]), RF_MAX_W'(wr_data),
                                             RF_MAX_BE'(wr_be)));

  always_comb begin
    w_state_d = r_state;
    w_ptr_d   = r_ptr;
    unique case (r_state)
      RF_IDLE: begin
        if (clr_req) begin
          w_state_d = RF_CLEAR;
          w_ptr_d   = '0;
        end
      end
      RF_CLEAR: begin
        // Pointer wraps to 0 on the edge that clears the last entry.
        w_ptr_d = r_ptr + 1'b1;
        if (r_ptr == ADDR_W'(DEPTH - 1)) begin
          w_state_d = RF_IDLE;
        end
      end
      default: begin
        w_state_d = RF_IDLE;
        w_ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RF_IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_d;
      r_ptr   <= w_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (busy) begin
      r_mem[r_ptr] <= '0;
    end else if (w_wr_acc) begin
      r_mem[wr_addr] <= w_wr_merged;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    regfile_rd_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) u_rd_port (
      .i_rd_addr  (rd_addr[k*ADDR_W +: ADDR_W]),
      .i_mem      (r_mem),
      .i_wr_acc   (w_wr_acc),
      .i_wr_addr  (wr_addr),
      .i_wr_merged(w_wr_merged),
      .o_rd_data  (rd_data[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param; expected values go through a scoreboard queue.
module tb_regfile_param;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic [9:0]  rd_addr;
  logic        clr_req;
  logic        wr_ok, busy;
  logic [63:0] rd_data;
  logic        nb_wr_ok, nb_busy;
  logic [63:0] nb_rd_data;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q [$];

  regfile_param dut (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_be  (wr_be),
    .wr_ok  (wr_ok),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .clr_req(clr_req),
    .busy   (busy)
  );

  // Same stimulus, bypass disabled.
  regfile_param #(.BYPASS(0)) dut_nb (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_be  (wr_be),
    .wr_ok  (nb_wr_ok),
    .rd_addr(rd_addr),
    .rd_data(nb_rd_data),
    .clr_req(clr_req),
    .busy   (nb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_v(input logic [31:0] e);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    e = exp_q.pop_front();
    n_tests++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  task automatic rd(input int a0, input int a1);
    rd_addr = {a1[4:0], a0[4:0]};
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
    wr_en   = 1'b1;
    wr_addr = a[4:0];
    wr_data = d;
    wr_be   = be;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic fill_index();
    for (int a = 0; a < 32; a++) begin
      wr(a, a, 4'hF);
    end
  endtask

  initial begin
    int cnt;
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rd_addr = '0; clr_req = 1'b0;
    #1;
    expect_v(32'd0); chk("busy_in_reset", {31'd0, busy});
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    #1;

    // Reset contents
    for (int a = 0; a < 32; a++) begin
      rd(a, a);
      expect_v(32'd0); chk("rst_p0", rd_data[31:0]);
      expect_v(32'd0); chk("rst_p1", rd_data[63:32]);
    end
    expect_v(32'd0); chk("rst_busy", {31'd0, busy});
    expect_v(32'd1); chk("rst_wr_ok", {31'd0, wr_ok});

    // Byte-enabled writes
    @(negedge clk);
    wr(5, 32'hDEADBEEF, 4'hF);
    wr(5, 32'h11223344, 4'b0101);
    rd(5, 5);
    expect_v(32'hDE22BE44); chk("be_merge", rd_data[31:0]);
    expect_v(32'hDE22BE44); chk("be_merge_nb", nb_rd_data[63:32]);

    // Same-cycle bypass on port 1
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5; wr_be = 4'hF;
    rd(5, 7);
    expect_v(32'hA5A5A5A5); chk("bypass_p1", rd_data[63:32]);
    expect_v(32'h00000000); chk("nobypass_p1", nb_rd_data[63:32]);
    expect_v(32'hDE22BE44); chk("bypass_other_p0", rd_data[31:0]);
    @(negedge clk);
    wr_en = 1'b0;
    rd(5, 7);
    expect_v(32'hA5A5A5A5); chk("nobypass_after", nb_rd_data[63:32]);

    // Partial bypass merge
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h00000000; wr_be = 4'b1000;
    rd(5, 0);
    expect_v(32'h0022BE44); chk("bypass_merge", rd_data[31:0]);
    expect_v(32'hDE22BE44); chk("nobypass_merge", nb_rd_data[31:0]);
    @(negedge clk);
    wr_en = 1'b0;
    rd(5, 0);
    expect_v(32'h0022BE44); chk("merge_commit", rd_data[31:0]);

    // Zero entry, including same-cycle bypass
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
    rd(0, 0);
    expect_v(32'd0); chk("zero_bypass_p0", rd_data[31:0]);
    expect_v(32'd0); chk("zero_bypass_p1", rd_data[63:32]);
    @(negedge clk);
    wr_en = 1'b0;
    rd(0, 0);
    expect_v(32'd0); chk("zero_after", rd_data[31:0]);

    // Fill, then clear with a simultaneous write to addr 3
    fill_index();
    rd(31, 17);
    expect_v(32'd31); chk("fill_31", rd_data[31:0]);
    expect_v(32'd17); chk("fill_17", rd_data[63:32]);
    clr_req = 1'b1;
    wr(3, 32'h00000055, 4'b0001);
    clr_req = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      if (cnt == 1) begin
        rd(3, 31);
        expect_v(32'h55); chk("clr_pre_write3", rd_data[31:0]);
        expect_v(32'd31); chk("clr_no_bypass", rd_data[63:32]);
        expect_v(32'd0);  chk("clr_wr_ok", {31'd0, wr_ok});
      end
      if (cnt == 5) clr_req = 1'b1;
      if (cnt == 6) clr_req = 1'b0;
      if (cnt == 20) begin
        rd(3, 25);
        expect_v(32'd0);  chk("clr_done3", rd_data[31:0]);
        expect_v(32'd25); chk("clr_pending25", rd_data[63:32]);
      end
      @(negedge clk);
    end
    wr_en = 1'b0;
    expect_v(32'd32); chk("clr_len", cnt);
    for (int a = 0; a < 32; a++) begin
      rd(a, 31 - a);
      expect_v(32'd0); chk("clr_all_p0", rd_data[31:0]);
      expect_v(32'd0); chk("clr_all_p1", rd_data[63:32]);
    end
    expect_v(32'd1); chk("clr_wr_ok_after", {31'd0, wr_ok});

    // Reset in the middle of a clear
    @(negedge clk);
    fill_index();
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (9) @(negedge clk);
    expect_v(32'd1); chk("mid_busy", {31'd0, busy});
    reset = 1'b0;
    #1;
    expect_v(32'd0); chk("mid_rst_busy", {31'd0, busy});
    for (int a = 0; a < 32; a++) begin
      rd(a, a);
      expect_v(32'd0); chk("mid_rst_entry", rd_data[63:32]);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    expect_v(32'd32); chk("clr2_len", cnt);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised multi-read-port register file with byte-enabled writes, optional write-to-read bypass, optional hardwired zero entry and a sequenced bulk-clear engine. It is the next-generation datapath register file, replacing the fixed 32×32, two-read-port file. It sits between decode (read addresses) and writeback (write port). Storage is flop-based with asynchronous read.

## Interface

Parameters:
- `DATA_W`, default 32: entry width in bits; must be a multiple of 8.
- `ADDR_W`, default 5: address width; DEPTH = 2**ADDR_W.
- `NREAD`, default 2: number of read ports, 1..4.
- `ZERO_REG`, default 1: when 1, entry 0 always reads 0 and writes to it are discarded.
- `BYPASS`, default 1: when 1, a same-cycle accepted write is forwarded to matching read ports.

Ports:
- `clk`, input, 1: sole clock; everything is rising-edge.
- `reset`, input, 1: asynchronous, active-low; clears all state.
- `wr_en`, input, 1: write request.
- `wr_addr`, input, ADDR_W: write address.
- `wr_data`, input, DATA_W: write data.
- `wr_be`, input, DATA_W/8: byte enables; bit i covers data bits [8i+7:8i].
- `wr_ok`, output, 1: combinational; 1 when a write presented this cycle is accepted (= ~busy).
- `rd_addr`, input, NREAD*ADDR_W: packed read addresses; port k uses slice k.
- `rd_data`, output, NREAD*DATA_W: packed read data; port k uses slice k.
- `clr_req`, input, 1: bulk-clear request, sampled on a rising edge.
- `busy`, output, 1: registered; high while the clear engine runs.

## Operation

- Reset (`reset`=0, asynchronous):
  - All entries go to 0.
  - `busy`=0, state IDLE, clear pointer 0.
  - `wr_ok`=1 once reset is released.
- Write:
  - At the rising edge with `wr_en`=1 and `busy`=0, each byte i with `wr_be[i]`=1 is updated.
  - Bytes with `wr_be[i]`=0 keep their value.
  - `wr_be`=0 is a legal no-op.
  - Writes while `busy`=1 are dropped; `wr_ok`=0 signals the drop.
- Zero entry: with ZERO_REG=1, writes to address 0 are discarded and every read of address 0 returns 0, bypass included.
- Read:
  - Combinational; `rd_data` slice k = entry[rd_addr slice k].
  - Any number of ports may read the same address.
- Bypass (BYPASS=1):
  - Applies when an accepted write targets the read address and that address is not the zero entry.
  - The port returns the byte-merged value: new bytes where `wr_be`=1, stored bytes elsewhere.
  - With BYPASS=0, the port returns the stored value until the edge.
- Clear engine FSM, states IDLE and CLEAR:
  - IDLE→CLEAR: at an edge with `clr_req`=1. `busy` rises after that edge and the pointer is 0.
  - In CLEAR, each edge zeroes entry[ptr] and increments ptr.
  - CLEAR→IDLE: at the edge that clears entry DEPTH-1. `busy` falls after that edge and the pointer wraps to 0.
  - `clr_req` while in CLEAR is ignored; it is not queued.
  - Reads during CLEAR return the current contents, so cleared entries read 0 and pending entries keep their old values.
  - Bypass is never active during CLEAR, because no write is accepted.

## Timing

- Write-to-read latency:
  - 0 cycles with BYPASS=1.
  - 1 cycle (visible after the edge) with BYPASS=0.
- Clear duration: exactly DEPTH cycles of `busy`=1. With ADDR_W=5 that is 32 cycles; the first write is accepted at edge 33 after the request edge.
- Simultaneous `clr_req` and `wr_en` in IDLE: the write is accepted at that edge (`busy` is still 0). The clear then starts and zeroes that entry in its turn.
- `reset` asserted mid-clear: immediate return to IDLE with all entries 0 and `busy`=0.
- `wr_ok` depends only on `busy` and has no combinational path from `wr_en`.

## Structure

- Package `regfile_pkg` holds:
  - default constants `RF_DATA_W`=32 and `RF_ADDR_W`=5;
  - the FSM state enum `rf_state_t` {RF_IDLE, RF_CLEAR};
  - the byte-merge function (old, new, be).
- Sub-module `regfile_rd_port`, instantiated NREAD times via generate. It contains the address mux, the zero-entry override and the bypass compare/merge.
- The top level holds storage, write decode, byte merge and the clear FSM.

## Test plan

- Reset then read all 32 addresses on both ports → all 0; `busy`=0; `wr_ok`=1.
- Write 0xDEADBEEF to addr 5 with `wr_be`=4'b1111, then write 0x11223344 to addr 5 with `wr_be`=4'b0101 → addr 5 reads 0xDE22BE44.
- With BYPASS=1, same cycle: write 0xA5A5A5A5 to addr 7 and `rd_addr`=7 on port 1 → port 1 shows 0xA5A5A5A5 before the edge. With BYPASS=0 it shows the old value.
- Write 0xFFFFFFFF to addr 0 (ZERO_REG=1) → addr 0 reads 0, including in the same-cycle bypass case.
- Fill all entries with their index. Pulse `clr_req` together with a write of 0x55 to addr 3 → `busy` is high for exactly 32 cycles. Writes during that window give `wr_ok`=0 and are lost. Afterwards all entries read 0.
- Assert `reset` at clear cycle 10 → `busy`=0 immediately and all entries read 0. A subsequent `clr_req` runs a full 32 cycles.
